mem_access_sequencer: RTL and testbench
=======================================

Name: mem_access_sequencer

Overview:
- Multi-cycle load/store sequencer between the core's decode/execute stage and a handshaked data-memory port.
- Consumes data_read_en, data_write_en and data_size (funct3 encoding) from the control unit, plus the ALU address and rs2.
- Stalls the pipeline while the memory access is in flight, generates byte lanes, and returns aligned, sign- or zero-extended load data for writeback.
- Flags misaligned or illegal accesses and bus timeouts.

Parameters:
- DATA_W, 32, data and address width; only 32 is supported.
- TIMEOUT, 255, cycles mem_req may stay high without mem_ack before the access is aborted; range 1..255.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- data_read_en  in  1  load request from the control unit
- data_write_en  in  1  store request from the control unit
- data_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address from the ALU
- wdata  in  32  store data (rs2)
- stall  out  1  hold PC and pipeline registers
- rdata_out  out  32  extended load result
- access_err  out  1  one-cycle pulse: misaligned address or reserved data_size
- bus_fault  out  1  one-cycle pulse: memory timeout
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rdata  in  32  memory read data
- mem_ack  in  1  completion; valid only while mem_req = 1

Behaviour:
- Reset (asynchronous, immediate on rst_n low): state IDLE, timeout counter 0.
  - All outputs 0: stall, rdata_out, access_err, bus_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata.
- Definitions:
  - start = data_read_en | data_write_en.
  - If both enables are high, the access is a store and the read is ignored.
- States: IDLE, BUSY, DONE.
- IDLE, start with legal size and alignment:
  - Latch we, word address, be, wdata and size.
  - Next state BUSY.
  - stall = 1 combinationally in this cycle.
- IDLE, start with an illegal access:
  - Illegal means data_size is 011/110/111, H/HU/SH with addr[0] = 1, or W/SW with addr[1:0] ≠ 00. BU and HU are illegal for stores.
  - access_err = 1 for this cycle, stall = 0, no mem_req, stay IDLE.
  - Loads in this case write rdata_out = 0 at the clock edge.
- BUSY:
  - mem_req = 1 (registered). mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_req drops.
  - stall = 1.
  - mem_ack = 1: drop mem_req next cycle; for a load, register the extended rdata_out; go to DONE.
  - Otherwise the counter increments. Counter reaching TIMEOUT: drop mem_req, rdata_out = 0, bus_fault = 1 during the DONE cycle, go to DONE.
- DONE:
  - stall = 0 so the instruction retires this cycle; counter cleared.
  - Next state is always IDLE; start is not sampled in DONE, so the same instruction is never re-issued.
- Latency: mem_ack in the first mem_req cycle gives 2 stall cycles and 3 cycles total occupancy. Each extra ack wait adds one stall cycle.
- Back-to-back memory instructions:
  - The following instruction is seen in IDLE on the cycle after DONE.
  - One idle gap between accesses is mandatory.
- mem_ack while mem_req = 0 is ignored.
- Store lanes:
  - B: be = 0001 << addr[1:0]; wdata byte replicated ×4.
  - H: be = 0011 << {addr[1], 0}; wdata halfword replicated ×2.
  - W: be = 1111.
- Load extract:
  - Select the byte or halfword via addr[1:0].
  - data_size[2] = 0 sign-extends; data_size[2] = 1 zero-extends.
- rdata_out holds its value until the next load completes or faults. Stores do not change it.
- rst_n low in BUSY: mem_req falls asynchronously and the access is abandoned; the memory side must tolerate this.

Test Plan:
- LW addr 0x0000_1004, mem_rdata 0xDEAD_BEEF, ack on 3rd req cycle → mem_addr 0x1004, be 1111, stall high 4 cycles, rdata_out 0xDEAD_BEEF in DONE.
- LB addr 0x2003, mem_rdata 0x80xx_xxxx → rdata_out 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH addr 0x3002, wdata 0x1234_ABCD → mem_we 1, be 1100, mem_wdata 0xABCD_ABCD, rdata_out unchanged.
- LW addr 0x1002 → access_err pulse for 1 cycle, stall 0, mem_req never asserted. Reserved data_size 011 → same result.
- TIMEOUT = 4, no ack → mem_req high exactly 4 cycles, then bus_fault 1 cycle, rdata_out 0, stall drops in DONE.
- rst_n pulsed low on the 2nd BUSY cycle → mem_req and stall go 0 immediately. After release, a new LW completes normally.
- Two consecutive LW with ack in the first req cycle → 2 stall cycles each, one idle gap between them, second result correct.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between the execute stage and a req/ack data-memory port.
// Stalls the pipeline during the access, builds byte lanes and extends load data.
module mem_access_sequencer #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_read_en,
  input  logic              data_write_en,
  input  logic [2:0]        data_size,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata_out,
  output logic              access_err,
  output logic              bus_fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state;
  logic [7:0]        tmo_cnt;
  logic [2:0]        size_q;
  logic [1:0]        lo_q;
  logic              start;
  logic              is_store;
  logic              illegal;
  logic [3:0]        be_next;
  logic [DATA_W-1:0] wdata_next;
  logic [DATA_W-1:0] load_ext;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  // Decode of the incoming request; a store wins when both enables are high.
  always_comb begin
    start      = data_read_en | data_write_en;
    is_store   = data_write_en;
    illegal    = (data_size == 3'b011) || (data_size == 3'b110) || (data_size == 3'b111) ||
                 (is_store && data_size[2]) ||
                 ((data_size[1:0] == 2'b01) && addr[0]) ||
                 ((data_size[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    be_next    = 4'b1111;
    wdata_next = wdata;
    case (data_size[1:0])
      2'b00: begin
        be_next    = 4'b0001 << addr[1:0];
        wdata_next = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_next    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = wdata;
      end
    endcase
  end

  always_comb begin
    sel_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    sel_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q[1:0])
      2'b00:   load_ext = size_q[2] ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   load_ext = size_q[2] ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Gated by rst_n so nothing is asserted while reset is held.
  assign stall      = rst_n & ((state == BUSY) || ((state == IDLE) && start && !illegal));
  assign access_err = rst_n & (state == IDLE) & start & illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tmo_cnt   <= 8'd0;
      size_q    <= 3'b000;
      lo_q      <= 2'b00;
      rdata_out <= '0;
      bus_fault <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
    end else begin
      bus_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (illegal) begin
              if (!is_store) rdata_out <= '0;
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= {addr[DATA_W-1:2], 2'b00};
              mem_be    <= be_next;
              mem_wdata <= wdata_next;
              size_q    <= data_size;
              lo_q      <= addr[1:0];
              tmo_cnt   <= 8'd0;
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) rdata_out <= load_ext;
            state   <= DONE;
          end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
            mem_req   <= 1'b0;
            bus_fault <= 1'b1;
            if (!mem_we) rdata_out <= '0;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          tmo_cnt <= 8'd0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer, built with TIMEOUT = 4.
module tb_mem_access_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_read_en, data_write_en;
  logic [2:0]  data_size;
  logic [31:0] addr, wdata;
  logic        stall, access_err, bus_fault;
  logic [31:0] rdata_out;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  int          r_stall, r_req, r_cycles;
  logic        r_err, r_fault, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata_done;
  logic [3:0]  r_be;

  mem_access_sequencer #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_read_en(data_read_en), .data_write_en(data_write_en),
    .data_size(data_size), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata_out(rdata_out), .access_err(access_err), .bus_fault(bus_fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  // Starts at a negedge, holds the instruction until stall drops, returns at a negedge in IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] size,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rdat, input int ack_at);
    logic done;
    done = 1'b0;
    r_stall = 0; r_req = 0; r_cycles = 0; r_err = 1'b0; r_fault = 1'b0;
    r_we = 1'b0; r_addr = '0; r_wdata = '0; r_be = '0; r_rdata_done = '0;
    data_read_en = rd; data_write_en = wr; data_size = size; addr = a; wdata = wd;
    mem_rdata = rdat; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (stall) r_stall++;
      if (access_err) r_err = 1'b1;
      if (bus_fault) r_fault = 1'b1;
      if (mem_req) begin
        r_req++;
        if (r_req == 1) begin
          r_we = mem_we; r_addr = mem_addr; r_be = mem_be; r_wdata = mem_wdata;
        end
        mem_ack = (ack_at != 0) && (r_req == ack_at);
      end else begin
        mem_ack = 1'b0;
      end
      if (!stall) begin
        done = 1'b1;
        r_cycles = cyc + 1;
        r_rdata_done = rdata_out;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("[TB] FAIL access_bound stall still high after 40 cycles, required low");
    end
    @(posedge clk); #1;
    data_read_en = 1'b0; data_write_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; data_read_en = 1'b1; data_write_en = 1'b0; data_size = 3'b010;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall got=%b exp=0", stall); end
    checks++;
    if ({mem_req, mem_we, access_err, bus_fault, mem_be} !== 8'h00 ||
        rdata_out !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs req=%b we=%b err=%b flt=%b be=%h rdata=%h addr=%h wdata=%h exp all 0",
               mem_req, mem_we, access_err, bus_fault, mem_be, rdata_out, mem_addr, mem_wdata);
    end
    data_read_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_word();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3);
    checks++; if (r_addr !== 32'h0000_1004) begin failures++; $display("[TB] FAIL lw_addr got=%h exp=00001004", r_addr); end
    checks++; if (r_be !== 4'b1111) begin failures++; $display("[TB] FAIL lw_be got=%b exp=1111", r_be); end
    checks++; if (r_stall !== 4) begin failures++; $display("[TB] FAIL lw_stall_cycles got=%0d exp=4", r_stall); end
    checks++; if (r_req !== 3) begin failures++; $display("[TB] FAIL lw_req_cycles got=%0d exp=3", r_req); end
    checks++; if (r_rdata_done !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL lw_rdata got=%h exp=deadbeef", r_rdata_done); end
    checks++; if (r_we !== 1'b0) begin failures++; $display("[TB] FAIL lw_we got=%b exp=0", r_we); end
  endtask

  task automatic test_load_byte();
    run_access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8012_3456, 1);
    checks++; if (r_be !== 4'b1000) begin failures++; $display("[TB] FAIL lb_be got=%b exp=1000", r_be); end
    checks++; if (r_rdata_done !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL lb_rdata got=%h exp=ffffff80", r_rdata_done); end
    run_access(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h8012_3456, 1);
    checks++; if (r_rdata_done !== 32'h0000_0080) begin failures++; $display("[TB] FAIL lbu_rdata got=%h exp=00000080", r_rdata_done); end
  endtask

  task automatic test_load_half();
    run_access(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0, 32'h8012_3456, 2);
    checks++; if (r_rdata_done !== 32'hFFFF_8012) begin failures++; $display("[TB] FAIL lh_rdata got=%h exp=ffff8012", r_rdata_done); end
    checks++; if (r_stall !== 3) begin failures++; $display("[TB] FAIL lh_stall_cycles got=%0d exp=3", r_stall); end
    run_access(1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'h0, 32'hF012_B456, 1);
    checks++; if (r_rdata_done !== 32'h0000_B456) begin failures++; $display("[TB] FAIL lhu_rdata got=%h exp=0000b456", r_rdata_done); end
  endtask

  task automatic test_stores();
    run_access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h1234_ABCD, 32'h5555_5555, 1);
    checks++; if (r_we !== 1'b1) begin failures++; $display("[TB] FAIL sh_we got=%b exp=1", r_we); end
    checks++; if (r_be !== 4'b1100) begin failures++; $display("[TB] FAIL sh_be got=%b exp=1100", r_be); end
    checks++; if (r_wdata !== 32'hABCD_ABCD) begin failures++; $display("[TB] FAIL sh_wdata got=%h exp=abcdabcd", r_wdata); end
    checks++; if (r_addr !== 32'h0000_3000) begin failures++; $display("[TB] FAIL sh_addr got=%h exp=00003000", r_addr); end
    checks++; if (rdata_out !== 32'h0000_B456) begin failures++; $display("[TB] FAIL sh_rdata_kept got=%h exp=0000b456", rdata_out); end
    run_access(1'b1, 1'b1, 3'b000, 32'h0000_4001, 32'h0000_00A5, 32'h0, 1);
    checks++; if (r_we !== 1'b1) begin failures++; $display("[TB] FAIL sb_both_en_we got=%b exp=1", r_we); end
    checks++; if (r_be !== 4'b0010) begin failures++; $display("[TB] FAIL sb_be got=%b exp=0010", r_be); end
    checks++; if (r_wdata !== 32'hA5A5_A5A5) begin failures++; $display("[TB] FAIL sb_wdata got=%h exp=a5a5a5a5", r_wdata); end
    checks++; if (rdata_out !== 32'h0000_B456) begin failures++; $display("[TB] FAIL sb_rdata_kept got=%h exp=0000b456", rdata_out); end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'h1111_1111, 0);
    checks++; if (r_req !== 4) begin failures++; $display("[TB] FAIL tmo_req_cycles got=%0d exp=4", r_req); end
    checks++; if (r_stall !== 5) begin failures++; $display("[TB] FAIL tmo_stall_cycles got=%0d exp=5", r_stall); end
    checks++; if (r_fault !== 1'b1) begin failures++; $display("[TB] FAIL tmo_bus_fault got=%b exp=1", r_fault); end
    checks++; if (r_rdata_done !== 32'h0) begin failures++; $display("[TB] FAIL tmo_rdata got=%h exp=00000000", r_rdata_done); end
    #1;
    checks++; if (bus_fault !== 1'b0) begin failures++; $display("[TB] FAIL tmo_fault_pulse got=%b exp=0", bus_fault); end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0, 32'h0BAD_F00D, 1);
    checks++; if (r_stall !== 2 || r_cycles !== 3) begin failures++; $display("[TB] FAIL b2b_first stall=%0d cycles=%0d exp 2/3", r_stall, r_cycles); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_6004, 32'h0, 32'h1357_9BDF, 1);
    checks++; if (r_stall !== 2 || r_cycles !== 3) begin failures++; $display("[TB] FAIL b2b_second stall=%0d cycles=%0d exp 2/3", r_stall, r_cycles); end
    checks++; if (rdata_out !== 32'h1357_9BDF) begin failures++; $display("[TB] FAIL b2b_rdata got=%h exp=13579bdf", rdata_out); end
  endtask

  task automatic test_illegal();
    run_access(1'b0, 1'b1, 3'b100, 32'h0000_7000, 32'hFFFF_FFFF, 32'h0, 1);
    checks++; if (r_err !== 1'b1 || r_req !== 0) begin failures++; $display("[TB] FAIL sbu_illegal err=%b req=%0d exp 1/0", r_err, r_req); end
    checks++; if (rdata_out !== 32'h1357_9BDF) begin failures++; $display("[TB] FAIL sbu_rdata_kept got=%h exp=13579bdf", rdata_out); end
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 1);
    checks++; if (r_err !== 1'b1 || r_stall !== 0) begin failures++; $display("[TB] FAIL lw_misalign err=%b stall=%0d exp 1/0", r_err, r_stall); end
    #1;
    checks++; if (access_err !== 1'b0 || mem_req !== 1'b0) begin failures++; $display("[TB] FAIL lw_misalign_after err=%b req=%b exp 0/0", access_err, mem_req); end
    checks++; if (rdata_out !== 32'h0) begin failures++; $display("[TB] FAIL lw_misalign_rdata got=%h exp=00000000", rdata_out); end
    @(negedge clk);
    run_access(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 1);
    checks++; if (r_err !== 1'b1 || r_req !== 0 || r_stall !== 0) begin failures++; $display("[TB] FAIL reserved_size err=%b req=%0d stall=%0d exp 1/0/0", r_err, r_req, r_stall); end
  endtask

  task automatic test_reset_in_busy();
    data_read_en = 1'b1; data_write_en = 1'b0; data_size = 3'b010; addr = 32'h0000_1008;
    mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("[TB] FAIL busy_req_before_reset got=%b exp=1", mem_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("[TB] FAIL async_reset req=%b stall=%b exp 0/0", mem_req, stall); end
    data_read_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_100C, 32'h0, 32'hCAFE_F00D, 1);
    checks++; if (r_rdata_done !== 32'hCAFE_F00D || r_stall !== 2) begin failures++; $display("[TB] FAIL after_reset_lw rdata=%h stall=%0d exp cafef00d/2", r_rdata_done, r_stall); end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b0 || rdata_out !== 32'hCAFE_F00D) begin
      failures++; $display("[TB] FAIL stray_ack req=%b stall=%b rdata=%h exp 0/0/cafef00d", mem_req, stall, rdata_out);
    end
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_byte();
    test_load_half();
    test_stores();
    test_timeout();
    test_back_to_back();
    test_illegal();
    test_reset_in_busy();
    test_stray_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
